// File: rtl/hazard_control_gen_if.sv
// Hazard controller bundle: ID operand indices, per-stage destinations,
// cache/BTB status in; latch enables, bubble/flush, forward selects,
// BTB write and perf counters out.
interface hazard_control_gen_if #(
    parameter int RA_W  = 2,
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) ();
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic             use_rs;
    logic             use_rt;
    logic [RA_W-1:0]  dest_ex;
    logic [RA_W-1:0]  dest_m;
    logic [RA_W-1:0]  dest_wb;
    logic             regwr_ex;
    logic             regwr_m;
    logic             regwr_wb;
    logic             load_ex;
    logic             i_hit;
    logic             d_hit;
    logic             i_ready;
    logic             d_ready;
    logic             ctl_id;
    logic             taken_id;
    logic [PC_W-1:0]  pred_pc;
    logic [PC_W-1:0]  actual_pc;
    logic             clr_cnt;
    logic             pc_write;
    logic             id_write;
    logic             ex_write;
    logic             m_write;
    logic             wb_write;
    logic             bubble_ex;
    logic             flush_if;
    logic             btb_write;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs, rt, use_rs, use_rt,
        output dest_ex, dest_m, dest_wb,
        output regwr_ex, regwr_m, regwr_wb, load_ex,
        output i_hit, d_hit, i_ready, d_ready,
        output ctl_id, taken_id, pred_pc, actual_pc, clr_cnt,
        input  pc_write, id_write, ex_write, m_write, wb_write,
        input  bubble_ex, flush_if, btb_write, fwd_a, fwd_b,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  rs, rt, use_rs, use_rt,
        input  dest_ex, dest_m, dest_wb,
        input  regwr_ex, regwr_m, regwr_wb, load_ex,
        input  i_hit, d_hit, i_ready, d_ready,
        input  ctl_id, taken_id, pred_pc, actual_pc, clr_cnt,
        output pc_write, id_write, ex_write, m_write, wb_write,
        output bubble_ex, flush_if, btb_write, fwd_a, fwd_b,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_control_gen.sv
// Single-issue pipeline hazard/stall controller: latch enables, EX bubble,
// IF flush, forwarding selects, BTB write, saturating stall/flush counters.
// Ports: clk, reset_n (async, active low), bus (hazard_control_gen_if.slave).
module hazard_control_gen #(
    parameter int RA_W     = 2,
    parameter int PC_W     = 16,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    hazard_control_gen_if.slave bus
);
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_MISS_I = 2'd1;
    localparam logic [1:0] S_MISS_D = 2'd2;
    localparam logic [1:0] S_LD     = 2'd3;

    localparam logic [3:0] LCNT_INIT = 4'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [3:0]       lcnt_q, lcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    function automatic logic same(input logic [RA_W-1:0] a,
                                  input logic [RA_W-1:0] b);
        return a == b;
    endfunction

    logic dep_ex_rs, dep_m_rs, dep_wb_rs;
    logic dep_ex_rt, dep_m_rt, dep_wb_rt;
    logic lu, nf;
    logic [PC_W-1:0] pc_x;
    logic mispred;

    assign dep_ex_rs = bus.use_rs & bus.regwr_ex & same(bus.rs, bus.dest_ex);
    assign dep_m_rs  = bus.use_rs & bus.regwr_m  & same(bus.rs, bus.dest_m);
    assign dep_wb_rs = bus.use_rs & bus.regwr_wb & same(bus.rs, bus.dest_wb);
    assign dep_ex_rt = bus.use_rt & bus.regwr_ex & same(bus.rt, bus.dest_ex);
    assign dep_m_rt  = bus.use_rt & bus.regwr_m  & same(bus.rt, bus.dest_m);
    assign dep_wb_rt = bus.use_rt & bus.regwr_wb & same(bus.rt, bus.dest_wb);

    assign lu = bus.load_ex & (dep_ex_rs | dep_ex_rt);
    // Without forwarding, any producer still in EX or M must drain first;
    // WB is covered by the write-before-read register file.
    assign nf = (FWD_EN == 0) &
                (dep_ex_rs | dep_ex_rt | dep_m_rs | dep_m_rt);

    assign pc_x    = bus.pred_pc ^ bus.actual_pc;
    assign mispred = |pc_x;

    logic [4:0] en;
    logic       bub;

    always_comb begin
        en      = 5'b00000;
        bub     = 1'b0;
        state_d = state_q;
        lcnt_d  = lcnt_q;
        unique case (state_q)
            S_RUN: begin
                if (!bus.d_hit) begin
                    state_d = S_MISS_D;
                end else if (!bus.i_hit) begin
                    en      = 5'b00111;
                    bub     = 1'b1;
                    state_d = S_MISS_I;
                end else if (lu || nf) begin
                    en  = 5'b00011;
                    bub = 1'b1;
                    if (lu && (LOAD_LAT > 1)) begin
                        lcnt_d  = LCNT_INIT;
                        state_d = S_LD;
                    end
                end else begin
                    en = 5'b11111;
                end
            end
            S_LD: begin
                if (!bus.d_hit) begin
                    state_d = S_MISS_D;
                end else begin
                    en     = 5'b00011;
                    bub    = 1'b1;
                    lcnt_d = lcnt_q - 4'd1;
                    // <=1 also recovers from a stray zero count
                    if (lcnt_q <= 4'd1) state_d = S_RUN;
                end
            end
            S_MISS_I: begin
                if (!bus.i_ready) begin
                    en  = 5'b00111;
                    bub = 1'b1;
                end else begin
                    en      = 5'b11111;
                    state_d = S_RUN;
                end
            end
            S_MISS_D: begin
                if (!bus.d_ready) begin
                    en = 5'b00000;
                end else if (!bus.i_hit) begin
                    en      = 5'b00111;
                    bub     = 1'b1;
                    state_d = S_MISS_I;
                end else begin
                    en      = 5'b11111;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    logic [1:0] fa, fb;

    always_comb begin
        fa = 2'd0;
        fb = 2'd0;
        if (FWD_EN != 0) begin
            if (dep_ex_rs)      fa = 2'd1;
            else if (dep_m_rs)  fa = 2'd2;
            else if (dep_wb_rs) fa = 2'd3;
            if (dep_ex_rt)      fb = 2'd1;
            else if (dep_m_rt)  fb = 2'd2;
            else if (dep_wb_rt) fb = 2'd3;
        end
    end

    // All outputs are held low while reset is asserted.
    logic adv;
    assign adv = reset_n & en[4];

    assign bus.pc_write  = adv;
    assign bus.id_write  = reset_n & en[3];
    assign bus.ex_write  = reset_n & en[2];
    assign bus.m_write   = reset_n & en[1];
    assign bus.wb_write  = reset_n & en[0];
    assign bus.bubble_ex = reset_n & bub;
    assign bus.flush_if  = adv & bus.ctl_id & mispred;
    assign bus.btb_write = adv & bus.ctl_id & bus.taken_id;
    assign bus.fwd_a     = reset_n ? fa : 2'd0;
    assign bus.fwd_b     = reset_n ? fb : 2'd0;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (bus.clr_cnt) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!bus.pc_write && stall_q != CNT_MAX)
                stall_d = stall_q + 1'b1;
            if (bus.flush_if && flush_q != CNT_MAX)
                flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RUN;
            lcnt_q  <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end
endmodule

// File: doc/hazard_control_gen.md
Name: hazard_control_gen

Overview:
- Parametrised successor to the single-issue pipeline hazard/stall controller.
- Sits between the datapath, control unit, I/D caches and BTB.
- Generates per-stage latch write enables, EX bubble, IF flush, forwarding selects and BTB write.
- New over the previous generation:
  - configurable register-index width;
  - configurable load-use latency, with a multi-cycle stall counter;
  - forwarding/no-forwarding mode;
  - handling of a simultaneous I- and D-miss;
  - saturating stall/flush performance counters.

Parameters:
RA_W, 2, register index width (number of registers = 2**RA_W)
PC_W, 16, PC / target width
LOAD_LAT, 1, load-use bubble cycles (legal range 1..15)
FWD_EN, 1, 1 = forward from EX/M/WB; 0 = stall on EX/M dependence, forward selects forced to 0
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
rs, rt  in  RA_W each  source register indices of the ID instruction
use_rs, use_rt  in  1 each  the ID instruction reads rs / rt
dest_ex, dest_m, dest_wb  in  RA_W each  destination register per stage
regwr_ex, regwr_m, regwr_wb  in  1 each  register write valid per stage
load_ex  in  1  EX holds a load
i_hit, d_hit  in  1 each  cache hit this cycle (d_hit=1 when no memory op)
i_ready, d_ready  in  1 each  miss fill complete
ctl_id  in  1  ID holds a branch or jump being resolved
taken_id  in  1  resolved taken, or a jump
pred_pc, actual_pc  in  PC_W each  predicted vs resolved next PC
clr_cnt  in  1  synchronous clear of both counters
pc_write, id_write, ex_write, m_write, wb_write  out  1 each  latch write enables
bubble_ex  out  1  insert NOP into ID/EX
flush_if  out  1  squash the IF instruction
btb_write  out  1  BTB update enable
fwd_a, fwd_b  out  2 each  0=RF, 1=EX, 2=M, 3=WB
stall_cnt  out  CNT_W  cycles with pc_write=0
flush_cnt  out  CNT_W  cycles with flush_if=1

Behaviour:
- Dependence: dep_x_s = use_s & regwr_x & (s == dest_x), for s in {rs, rt} and x in {ex, m, wb}.
- Forward priority (FWD_EN=1): EX > M > WB.
- Load-use hazard: lu = load_ex & (dep_ex_rs | dep_ex_rt).
- No-forward hazard (FWD_EN=0 only): nf = any dep_ex or dep_m. WB dependence never stalls; the RF is write-before-read.
- Outputs are combinational from state and inputs; the state, the load counter lcnt[3:0] and the perf counters are registered.
- Reset (async, reset_n=0):
  - all write enables 0; bubble_ex, flush_if, btb_write 0; fwd 0;
  - state=RUN, lcnt=0, counters 0.
- States: RUN, MISS_I, MISS_D, LD_STALL.
- RUN:
  - !d_hit -> all enables 0, next MISS_D (takes priority over i_hit).
  - else !i_hit -> enables 00111 (pc, id, ex, m, wb), bubble_ex=1, next MISS_I.
  - else lu or nf -> enables 00011, bubble_ex=1.
    - Case lu with LOAD_LAT>1: lcnt <= LOAD_LAT-1, next LD_STALL.
    - Otherwise stay RUN; the hazard is re-evaluated next cycle.
  - else advance: enables 11111.
- LD_STALL:
  - !d_hit -> freeze all, lcnt held, next MISS_D.
  - else enables 00011, bubble_ex=1, lcnt decrements; at lcnt==1 next RUN.
- MISS_I:
  - !i_ready -> enables 00111, bubble_ex=1.
  - i_ready -> advance cycle, enables 11111, next RUN.
- MISS_D:
  - !d_ready -> all enables 0.
  - d_ready, and i_hit=0 at that cycle -> enables 00111, bubble_ex=1, next MISS_I.
  - d_ready otherwise -> advance cycle, next RUN.
- Resolution applies only in advance cycles (pc_write=1):
  - flush_if = ctl_id & (pred_pc != actual_pc);
  - btb_write = ctl_id & taken_id.
  - Both are 0 in every stall cycle.
- Counters:
  - increment on the cycle edge when the event held;
  - saturate at 2**CNT_W-1;
  - clr_cnt wins over increment.

Test Plan:
- Forwarding: RA_W=3, rs=5 with dest_ex=5/regwr_ex=1 and dest_m=5/regwr_m=1 -> fwd_a=1. Clear the EX match -> fwd_a=2.
- Load-use: LOAD_LAT=3, load_ex=1, dest_ex=rs=2, use_rs=1 -> exactly 3 cycles of enables 00011 with bubble_ex=1, then 11111; stall_cnt=3.
- Dual miss: d_hit=0, i_hit=0 -> all enables 0 until d_ready; then 00111 until i_ready; then 11111. Path RUN->MISS_D->MISS_I->RUN.
- Mispredict: ctl_id=1, taken_id=1, pred_pc=0x0010, actual_pc=0x0020 -> flush_if=1, btb_write=1. Same stimulus during MISS_I -> both 0. flush_cnt=1.
- FWD_EN=0: dep_m on rt -> enables 00011 and fwd_b=0 until the dependence clears. A WB-only dependence causes no stall.
- Reset/saturation: reset_n low mid-LD_STALL -> state RUN, outputs 0. CNT_W=2 with 5 stall cycles -> stall_cnt=3; clr_cnt -> 0.
